// File: rtl/m68k_bus_pkg.sv
// Shared types and constants for the 68000-style bus initiator.
// The state enum, data-strobe lane encoding and default timeout live here.
package m68k_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_ASSERT = 3'd2,
    ST_WAIT   = 3'd3,
    ST_END    = 3'd4
  } state_e;

  // Lane vector: bit 1 selects UDS (D15:8), bit 0 selects LDS (D7:0).
  localparam logic [1:0] LANE_NONE  = 2'b00;
  localparam logic [1:0] LANE_LOWER = 2'b01;
  localparam logic [1:0] LANE_UPPER = 2'b10;
  localparam logic [1:0] LANE_BOTH  = 2'b11;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

  function automatic logic [1:0] lane_select(input logic byte_acc, input logic addr0);
    logic [1:0] lanes;
    if (byte_acc) begin
      lanes = addr0 ? LANE_LOWER : LANE_UPPER;
    end else begin
      lanes = LANE_BOTH;
    end
    return lanes;
  endfunction

endpackage

// File: rtl/dtack_sync.sv
// Flip-flop chain that brings an asynchronous level into the clock domain.
// Usable for DTACK, IORDY or any other slow asynchronous input; depth must be at least 2.
module dtack_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/m68k_bus_initiator.sv
// Bus master that runs one 68000-style asynchronous read or write per request.
// Sequences AS/UDS/LDS/RW, waits for a synchronised DTACK with timeout, and returns data or err.
module m68k_bus_initiator
  import m68k_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        req,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [23:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        done,
  output logic        err,
  output logic [15:0] rdata,
  output logic [22:0] ADDR,
  output logic        AS_n,
  output logic        UDS_n,
  output logic        LDS_n,
  output logic        RW,
  output logic [15:0] DATA_OUT,
  output logic        DATA_OE,
  input  logic [15:0] DATA_IN,
  input  logic        DTACK
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e             state_q, state_d;
  logic               write_q, write_d;
  logic               byte_q, byte_d;
  logic               a0_q, a0_d;
  logic               misal_q, misal_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic [22:0]        addr_q, addr_d;
  logic               as_n_q, as_n_d;
  logic               uds_n_q, uds_n_d;
  logic               lds_n_q, lds_n_d;
  logic               rw_q, rw_d;
  logic [15:0]        dout_q, dout_d;
  logic               doe_q, doe_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [15:0]        rdata_q, rdata_d;
  logic [1:0]         lanes_s;
  logic               dtack_s;
  logic               req_ready_s;

  dtack_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_dtack_sync (
    .clk_i  (CLK),
    .rst_ni (RESET_n),
    .async_i(DTACK),
    .sync_o (dtack_s)
  );

  // A responder still holding DTACK from the last cycle blocks the next one.
  assign req_ready_s = (state_q == ST_IDLE) && !dtack_s;
  assign lanes_s     = lane_select(byte_q, a0_q);
  assign cnt_inc_s   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    byte_d  = byte_q;
    a0_d    = a0_q;
    misal_d = misal_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    as_n_d  = as_n_q;
    uds_n_d = uds_n_q;
    lds_n_d = lds_n_q;
    rw_d    = rw_q;
    dout_d  = dout_q;
    doe_d   = doe_q;
    done_d  = 1'b0;
    err_d   = err_q;
    rdata_d = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req && req_ready_s) begin
          write_d = req_write;
          byte_d  = req_byte;
          a0_d    = req_addr[0];
          misal_d = !req_byte && req_addr[0];
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_ADDR;
          // A misaligned word access leaves the bus completely untouched.
          if (!(!req_byte && req_addr[0])) begin
            addr_d = req_addr[23:1];
            rw_d   = !req_write;
            if (req_write) begin
              dout_d = req_byte ? {req_wdata[7:0], req_wdata[7:0]} : req_wdata;
              doe_d  = 1'b1;
            end else begin
              doe_d  = 1'b0;
            end
          end else begin
            rw_d  = 1'b1;
            doe_d = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ADDR: begin
        state_d = ST_ASSERT;
        if (!misal_q) begin
          as_n_d = 1'b0;
          if (!write_q) begin
            uds_n_d = !lanes_s[1];
            lds_n_d = !lanes_s[0];
          end else begin
            uds_n_d = 1'b1;
            lds_n_d = 1'b1;
          end
        end else begin
          as_n_d = 1'b1;
        end
      end

      ST_ASSERT: begin
        if (misal_q) begin
          state_d = ST_END;
          err_d   = 1'b1;
          done_d  = 1'b1;
        end else begin
          state_d = ST_WAIT;
          // Write strobes trail AS_n by one clock so data is set up first.
          if (write_q) begin
            uds_n_d = !lanes_s[1];
            lds_n_d = !lanes_s[0];
          end else begin
            uds_n_d = uds_n_q;
            lds_n_d = lds_n_q;
          end
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_inc_s;
        if (dtack_s) begin
          state_d = ST_END;
          err_d   = 1'b0;
          done_d  = 1'b1;
          as_n_d  = 1'b1;
          uds_n_d = 1'b1;
          lds_n_d = 1'b1;
          if (!write_q) begin
            if (!byte_q) begin
              rdata_d = DATA_IN;
            end else if (a0_q) begin
              rdata_d = {8'h00, DATA_IN[7:0]};
            end else begin
              rdata_d = {8'h00, DATA_IN[15:8]};
            end
          end else begin
            rdata_d = rdata_q;
          end
        end else if (cnt_inc_s == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d = ST_END;
          err_d   = 1'b1;
          done_d  = 1'b1;
          as_n_d  = 1'b1;
          uds_n_d = 1'b1;
          lds_n_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_END: begin
        // ADDR and DATA_OUT keep their last value; only RW and the driver enable release.
        state_d = ST_IDLE;
        rw_d    = 1'b1;
        doe_d   = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        as_n_d  = 1'b1;
        uds_n_d = 1'b1;
        lds_n_d = 1'b1;
        rw_d    = 1'b1;
        doe_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      byte_q  <= 1'b0;
      a0_q    <= 1'b0;
      misal_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      addr_q  <= 23'd0;
      as_n_q  <= 1'b1;
      uds_n_q <= 1'b1;
      lds_n_q <= 1'b1;
      rw_q    <= 1'b1;
      dout_q  <= 16'h0000;
      doe_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      byte_q  <= byte_d;
      a0_q    <= a0_d;
      misal_q <= misal_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      as_n_q  <= as_n_d;
      uds_n_q <= uds_n_d;
      lds_n_q <= lds_n_d;
      rw_q    <= rw_d;
      dout_q  <= dout_d;
      doe_q   <= doe_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready = req_ready_s;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign ADDR      = addr_q;
  assign AS_n      = as_n_q;
  assign UDS_n     = uds_n_q;
  assign LDS_n     = lds_n_q;
  assign RW        = rw_q;
  assign DATA_OUT  = dout_q;
  assign DATA_OE   = doe_q;

endmodule

// File: tb/tb_m68k_bus_initiator.sv
// Directed bench for m68k_bus_initiator with a behavioural responder.
// Stimulus pushes expected {err, rdata} per request; a monitor pops on every done.
module tb_m68k_bus_initiator;

  localparam int RESP_NONE    = 0;
  localparam int RESP_COMB    = 1;
  localparam int RESP_STRETCH = 2;

  logic        CLK;
  logic        RESET_n;
  logic        req;
  logic        req_ready;
  logic        req_write;
  logic        req_byte;
  logic [23:0] req_addr;
  logic [15:0] req_wdata;
  logic        done;
  logic        err;
  logic [15:0] rdata;
  logic [22:0] ADDR;
  logic        AS_n;
  logic        UDS_n;
  logic        LDS_n;
  logic        RW;
  logic [15:0] DATA_OUT;
  logic        DATA_OE;
  logic [15:0] DATA_IN;
  logic        DTACK;

  int          resp_mode;
  logic [1:0]  hold_q;
  logic [16:0] exp_q[$];
  logic [16:0] exp_item;
  int          n_checks;
  int          n_errors;

  m68k_bus_initiator #(
    .TIMEOUT_CYCLES(8),
    .SYNC_STAGES   (2)
  ) dut (
    .CLK      (CLK),
    .RESET_n  (RESET_n),
    .req      (req),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_byte (req_byte),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .done     (done),
    .err      (err),
    .rdata    (rdata),
    .ADDR     (ADDR),
    .AS_n     (AS_n),
    .UDS_n    (UDS_n),
    .LDS_n    (LDS_n),
    .RW       (RW),
    .DATA_OUT (DATA_OUT),
    .DATA_OE  (DATA_OE),
    .DATA_IN  (DATA_IN),
    .DTACK    (DTACK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Stretching responder keeps DTACK up for three clocks after AS_n rises.
  always @(posedge CLK) begin
    if (!AS_n) hold_q <= 2'd3;
    else if (hold_q != 2'd0) hold_q <= hold_q - 2'd1;
  end

  assign DTACK = (resp_mode == RESP_COMB)    ? !AS_n :
                 (resp_mode == RESP_STRETCH) ? (!AS_n || (hold_q != 2'd0)) : 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always begin
    @(posedge CLK);
    #1;
    if (RESET_n && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL done_unexpected: got err=%b rdata=%h with nothing expected at %0t", err, rdata, $time);
      end else begin
        exp_item = exp_q.pop_front();
        check("done_resp", {15'd0, err, rdata}, {15'd0, exp_item});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    while (!req_ready && k < 60) begin
      tick(1);
      k++;
    end
    check({name, "_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  // Present a request, let the next edge accept it, return 1 time unit after that edge.
  task automatic issue(input logic wr, input logic by, input logic [23:0] a, input logic [15:0] wd);
    req       = 1'b1;
    req_write = wr;
    req_byte  = by;
    req_addr  = a;
    req_wdata = wd;
    tick(1);
    req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    resp_mode = RESP_NONE;
    RESET_n   = 1'b0;
    req       = 1'b0;
    req_write = 1'b0;
    req_byte  = 1'b0;
    req_addr  = 24'h000000;
    req_wdata = 16'h0000;
    DATA_IN   = 16'h0000;
    #12;
    check("rst_strobes", {28'd0, AS_n, UDS_n, LDS_n, RW}, 32'hF);
    check("rst_oe_done_err", {29'd0, DATA_OE, done, err}, 32'd0);
    check("rst_rdata_addr_dout", {rdata, DATA_OUT} | {9'd0, ADDR}, 32'd0);
    @(negedge CLK);
    RESET_n = 1'b1;
    wait_ready("init");

    // Word read, combinational responder
    resp_mode = RESP_COMB;
    DATA_IN   = 16'h1234;
    exp_q.push_back({1'b0, 16'h1234});
    issue(1'b0, 1'b0, 24'hE90000, 16'h0000);
    check("rd_addr", {9'd0, ADDR}, 32'h748000);
    check("rd_as_before", {31'd0, AS_n}, 32'd1);
    tick(1);
    check("rd_strobes_low", {29'd0, AS_n, UDS_n, LDS_n}, 32'd0);
    tick(2);
    check("rd_done_early", {31'd0, done}, 32'd0);
    tick(1);
    check("rd_done_lat4", {31'd0, done}, 32'd1);
    wait_ready("rd");

    // Byte write to odd address
    exp_q.push_back({1'b0, 16'h1234});
    issue(1'b1, 1'b1, 24'hE90003, 16'hAB5A);
    check("bw_bus", {RW, DATA_OE, AS_n, 13'd0, DATA_OUT}, {3'b011, 13'd0, 16'h5A5A});
    check("bw_addr", {9'd0, ADDR}, 32'h748001);
    tick(1);
    check("bw_as_only", {29'd0, AS_n, UDS_n, LDS_n}, 32'b011);
    tick(1);
    check("bw_lds", {29'd0, AS_n, UDS_n, LDS_n}, 32'b010);
    tick(2);
    check("bw_end", {27'd0, done, AS_n, UDS_n, LDS_n, RW}, 32'b11110);
    check("bw_end_oe", {31'd0, DATA_OE}, 32'd1);
    tick(1);
    check("bw_release", {30'd0, RW, DATA_OE}, 32'b10);
    wait_ready("bw");

    // Word write
    exp_q.push_back({1'b0, 16'h1234});
    issue(1'b1, 1'b0, 24'h001000, 16'hA55A);
    check("ww_dout", {16'd0, DATA_OUT}, 32'hA55A);
    tick(2);
    check("ww_both_ds", {29'd0, AS_n, UDS_n, LDS_n}, 32'd0);
    wait_ready("ww");

    // Timeout with silent responder
    resp_mode = RESP_NONE;
    exp_q.push_back({1'b1, 16'h1234});
    issue(1'b0, 1'b0, 24'h000100, 16'h0000);
    tick(9);
    check("to_waiting", {30'd0, done, AS_n}, 32'b00);
    tick(1);
    check("to_end", {28'd0, done, AS_n, UDS_n, LDS_n}, 32'hF);
    wait_ready("to");

    // Misaligned word read
    exp_q.push_back({1'b1, 16'h1234});
    issue(1'b0, 1'b0, 24'h000001, 16'h0000);
    check("mis_e0", {30'd0, AS_n, RW}, 32'b11);
    tick(1);
    check("mis_e1", {30'd0, AS_n, done}, 32'b10);
    tick(1);
    check("mis_e2", {30'd0, AS_n, done}, 32'b11);
    wait_ready("mis");

    // Back-to-back with stretched DTACK, req held high
    resp_mode = RESP_STRETCH;
    DATA_IN   = 16'hBEEF;
    exp_q.push_back({1'b0, 16'hBEEF});
    exp_q.push_back({1'b0, 16'hBEEF});
    req       = 1'b1;
    req_write = 1'b0;
    req_byte  = 1'b0;
    req_addr  = 24'h000200;
    tick(5);
    for (int k = 5; k <= 8; k++) begin
      tick(1);
      check("b2b_blocked", {30'd0, req_ready, AS_n}, 32'b01);
    end
    tick(1);
    check("b2b_ready", {31'd0, req_ready}, 32'd1);
    tick(1);
    req = 1'b0;
    check("b2b_as_hold", {31'd0, AS_n}, 32'd1);
    tick(1);
    check("b2b_as_second", {31'd0, AS_n}, 32'd0);
    wait_ready("b2b");

    // Asynchronous reset mid-WAIT
    resp_mode = RESP_NONE;
    issue(1'b0, 1'b0, 24'h000300, 16'h0000);
    tick(3);
    check("rw_in_wait", {31'd0, AS_n}, 32'd0);
    RESET_n = 1'b0;
    #1;
    check("rw_strobes", {27'd0, AS_n, UDS_n, LDS_n, RW, DATA_OE}, 32'b11110);
    check("rw_done_rdata", {15'd0, done, rdata}, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    RESET_n = 1'b1;
    wait_ready("rw");

    // Byte reads after reset, both lanes
    resp_mode = RESP_COMB;
    DATA_IN   = 16'h12CD;
    exp_q.push_back({1'b0, 16'h0012});
    issue(1'b0, 1'b1, 24'hE90000, 16'h0000);
    tick(1);
    check("br_even_ds", {29'd0, AS_n, UDS_n, LDS_n}, 32'b001);
    wait_ready("br_even");
    exp_q.push_back({1'b0, 16'h00CD});
    issue(1'b0, 1'b1, 24'hE90001, 16'h0000);
    tick(1);
    check("br_odd_ds", {29'd0, AS_n, UDS_n, LDS_n}, 32'b010);
    wait_ready("br_odd");

    tick(5);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/m68k_bus_initiator.md
Name: m68k_bus_initiator

Overview:
- Bus-master engine that runs 68000-style asynchronous bus cycles (AS_n, UDS_n/LDS_n, RW, DTACK) against on-board responders such as the IDE port and Zorro slots.
- It is the initiator for the responder logic already in the design.
- Internal logic issues one read or write through a simple request/done handshake.
- The engine sequences the address and data strobes, synchronises DTACK, enforces a timeout, and returns read data or an error.

Parameters:
- TIMEOUT_CYCLES, 255, clocks spent in WAIT without DTACK before the cycle is aborted with err; range 1..65535.
- SYNC_STAGES, 2, flip-flop depth of the DTACK synchroniser; minimum 2.

Ports:
- CLK  in  1  system clock.
- RESET_n  in  1  asynchronous active-low reset.
- req  in  1  request strobe; sampled only while req_ready=1.
- req_ready  out  1  engine can accept a request.
- req_write  in  1  1=write, 0=read.
- req_byte  in  1  1=byte access, 0=word access.
- req_addr  in  24  byte address.
- req_wdata  in  16  write data; byte writes use bits [7:0].
- done  out  1  one-clock completion pulse.
- err  out  1  valid with done; 1 = timeout or misaligned access.
- rdata  out  16  read data; valid with done, held until the next done.
- ADDR  out  23  bus address [23:1].
- AS_n  out  1  address strobe.
- UDS_n  out  1  upper data strobe (D15:8).
- LDS_n  out  1  lower data strobe (D7:0).
- RW  out  1  1=read, 0=write.
- DATA_OUT  out  16  write data to the bus.
- DATA_OE  out  1  bus data driver enable.
- DATA_IN  in  16  read data from the bus.
- DTACK  in  1  active-high acknowledge from responder decode; asynchronous.

Behaviour:
- Reset (asynchronous, immediate, including mid-cycle):
  - AS_n=UDS_n=LDS_n=1, RW=1, DATA_OE=0.
  - done=0, err=0, rdata=0, ADDR=0, DATA_OUT=0.
  - Synchroniser cleared; state=IDLE; timeout counter=0.
- DTACK passes through SYNC_STAGES flip-flops to give dtack_s. Only dtack_s is used.
- req_ready = (state==IDLE) && !dtack_s. No new cycle starts until the previous responder has released DTACK.
- Lane select:
  - Word access: UDS and LDS both asserted.
  - Byte access at even address: UDS only. Byte at odd address: LDS only.
  - Byte write: req_wdata[7:0] replicated onto both DATA_OUT halves.
- Read data: a byte read at an even address returns D15:8 in rdata[7:0]; odd address returns D7:0. rdata[15:8]=0 for byte reads.
- Misaligned word request (req_byte=0, req_addr[0]=1): no bus activity. Go straight to END with err=1.
- States:
  - IDLE: on req&&req_ready, latch the request and go to ADDR. A req while not ready is ignored; requesters must hold req.
  - ADDR (1 clk): drive ADDR, RW, and for writes DATA_OUT with DATA_OE=1. AS_n and DS remain 1.
  - ASSERT (1 clk): AS_n=0. For reads, the selected DS go 0.
  - WAIT: for writes, the selected DS go 0 on entry, one clock after AS_n. The timeout counter increments each clock.
    - dtack_s=1 → END. For reads, rdata is captured from DATA_IN on this edge.
    - Counter reaches TIMEOUT_CYCLES → END with err=1.
    - dtack_s and timeout on the same edge: the acknowledge wins, err=0.
  - END (1 clk):
    - AS_n, UDS_n and LDS_n are all 1 on entry.
    - RW, ADDR and DATA_OUT/DATA_OE are held through END for write hold time.
    - done=1 for this clock only.
  - Exit from END: → IDLE. RW returns to 1 and DATA_OE to 0 on that edge.
- Latency with a responder that asserts DTACK combinationally on AS_n low and SYNC_STAGES=2:
  - Accept at edge 0, AS_n low after edge 1.
  - done high between edge 4 and edge 5.
  - Each extra DTACK delay clock adds one clock.
- Timeout counter width is clog2(TIMEOUT_CYCLES+1); it is cleared on every entry to ADDR.

Decomposition:
- Shared package m68k_bus_pkg holds:
  - the state enum (IDLE, ADDR, ASSERT, WAIT, END);
  - lane-select constants;
  - the default TIMEOUT_CYCLES.
- One sub-module is natural: dtack_sync, a parameterised SYNC_STAGES flip-flop chain with asynchronous clear. It is reusable for IORDY and other asynchronous inputs.

Test Plan:
- Word read, addr 0xE90000, responder DTACK=!AS_n, DATA_IN=0x1234 → AS_n low 1 clk after accept; UDS_n=LDS_n=0 with AS_n; done 4 clks after accept with rdata=0x1234, err=0.
- Byte write, addr 0xE90003, wdata 0x5A → RW=0, DATA_OUT=0x5A5A, LDS_n low one clock after AS_n, UDS_n stays 1; RW/DATA_OE held through END, released the next clock.
- Responder never acknowledges, TIMEOUT_CYCLES=8 → done with err=1 after 8 WAIT clocks; strobes negated; rdata unchanged.
- Misaligned word read at 0x000001 → AS_n never asserted; done+err=1 two clocks after accept.
- Responder holds DTACK high 3 clocks past AS_n negation, with back-to-back req held high → req_ready stays 0 until dtack_s falls; second AS_n assertion only afterwards.
- RESET_n pulsed low while in WAIT with AS_n=0 → AS_n/UDS_n/LDS_n/RW=1 and DATA_OE=0 immediately, no done; after reset release a fresh read completes normally.
